inv_mix_columns_iter: RTL and testbench
=======================================

# inv_mix_columns_iter

Iterative InvMixColumns stage for the AES decryptor datapath. It sits directly downstream of the decryptor's AddRoundKey stage in inverse rounds 1–9 and consumes that stage's 128-bit output. It transforms one 32-bit state column per clock, four cycles per block, and presents the result with a one-cycle `Ry` strobe. The `En`/`Ry` handshake matches the neighbouring round stages, so the round controller can chain them.

## Interface
- No parameters; all widths are fixed by AES-128.
- `Clk`  in  1  rising-edge clock.
- `Rst`  in  1  reset, asynchronous and active-high.
- `En`  in  1  start request; sampled only in IDLE.
- `Text`  in  128  input state from AddRoundKey; captured on the accepting edge.
- `Ry`  out  1  result-ready strobe; high for exactly one cycle per block.
- `ModifiedText`  out  128  InvMixColumns result; holds its value until the next block completes.

## Operation
- **State byte order:**
  - `Text[127:120]` is byte 0; byte k sits at `[127-8k -: 8]`.
  - Column c is bytes 4c..4c+3, with row 0 in the MSB byte. Column 0 is `[127:96]`; column 3 is `[31:0]`.
- **Per-column transform** (a0..a3 in, b0..b3 out, all GF(2^8), reduction polynomial 0x11B):
  - b0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0E·a1 ^ 0B·a2 ^ 0D·a3
  - b2 = 0D·a0 ^ 09·a1 ^ 0E·a2 ^ 0B·a3
  - b3 = 0B·a0 ^ 0D·a1 ^ 09·a2 ^ 0E·a3
- **Constant multiplies:** built from `xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 0)`; there are no multipliers or lookup tables.
- **Datapath:** one shared column datapath is applied to columns 0,1,2,3 in that order.
- **Registers:**
  - `work[127:0]` holds the captured input.
  - `acc[127:0]` collects the per-column results.
  - A 2-bit column counter `col`.
- **FSM:**
  - **IDLE:** if `En`=1 at a rising edge: `work`←`Text`, `col`←0, go to BUSY. Otherwise stay in IDLE.
  - **BUSY:** each edge writes the transformed column `col` of `work` into column `col` of `acc`, then `col`←`col`+1.
    - On the edge that processes `col`=3: `ModifiedText`←final value (`acc` with column 3 substituted), `Ry`←1, go to IDLE.
  - `En` is ignored throughout BUSY. A request raised during BUSY is not queued; it must still be high in IDLE to be accepted.
- **Ry:** cleared on every edge where a block does not complete.
- **ModifiedText:** never shows partial results; it changes only on the completion edge.
- **Reset, from any state including mid-block:** state=IDLE, `col`=0, `work`=0, `acc`=0, `ModifiedText`=0, `Ry`=0. An in-flight block is discarded and produces no `Ry`.

## Timing
- **Latency:** `En` accepted at edge N gives `Ry`=1 and a valid `ModifiedText` after edge N+4.
- **Ry duration:** high during cycle N+4→N+5 only.
- **Throughput:** the FSM is IDLE after edge N+4, so a new `En` is accepted at edge N+5 at the earliest. That is one block per 5 cycles.
- **Back-to-back:** if `En` is held continuously high, blocks are accepted at N, N+5, N+10, … and `Ry` pulses at N+4, N+9, …
- **Input hold:** `Text` must be valid only at the accepting edge; later changes have no effect.
- **Reset timing:** reset deasserting synchronously to `Clk` is the caller's responsibility. The first accept is possible at the first edge after release.

## Test plan
- **Reset values:** assert `Rst` mid-cycle with no clock → `Ry`=0, `ModifiedText`=0 immediately. After release, hold `En`=0 for 10 cycles → `Ry` never rises.
- **FIPS-197 columns:** `Text`=8E4DA1BC_9FDC589D_01010101_C6C6C6C6, one-cycle `En` → exactly 4 edges later `ModifiedText`=DB135345_F20A225C_01010101_C6C6C6C6, `Ry` high for 1 cycle.
- **Second vector:** `Text`=D5D5D7D6_4D7EBDF8_00000000_FFFFFFFF → `ModifiedText`=D4D4D4D5_2D26314C_00000000_FFFFFFFF.
- **Mid-block stability:** change `Text` and pulse `En` during BUSY → result still equals the first block's answer, and no extra `Ry`. `ModifiedText` keeps its previous value until the completion edge.
- **Held En:** hold `En`=1 for 20 cycles with alternating vectors → `Ry` at accept+4 with a 5-cycle period, each result correct.
- **Reset mid-block:** assert `Rst` at accept+2 → no `Ry`, `ModifiedText`=0. A fresh block after release completes correctly in 4 cycles.

Source files
------------

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one 32-bit column per cycle through a shared column datapath.
// Latency: En accepted at edge N -> Ry pulse and ModifiedText valid after edge N+4; one block per 5 cycles.
// Backpressure: none; En is sampled only when idle, requests during a block are dropped, Ry is a 1-cycle strobe.
module inv_mix_columns_iter (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         En,
    input  logic [127:0] Text,
    output logic         Ry,
    output logic [127:0] ModifiedText
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   col;
    logic [127:0] work;
    logic [127:0] acc;
    logic [127:0] acc_nxt;
    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic         load;
    logic         step;
    logic         done;

    // multiply by 02 in GF(2^8) modulo 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // one column of InvMixColumns; row 0 is the most significant byte
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [3:0][7:0] a;
        logic [3:0][7:0] x2;
        logic [3:0][7:0] x4;
        logic [3:0][7:0] x8;
        logic [3:0][7:0] m9;
        logic [3:0][7:0] mb;
        logic [3:0][7:0] md;
        logic [3:0][7:0] me;
        a[0] = c[31:24];
        a[1] = c[23:16];
        a[2] = c[15:8];
        a[3] = c[7:0];
        for (int i = 0; i < 4; i++) begin
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // FSM state register; reset discards any block in flight
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and datapath control strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (En) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (col == 2'd3) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // select current column, transform it, and merge it into the accumulator image
    always_comb begin
        col_in = work[127:96];
        case (col)
            2'd0: col_in = work[127:96];
            2'd1: col_in = work[95:64];
            2'd2: col_in = work[63:32];
            2'd3: col_in = work[31:0];
        endcase
        col_out = inv_mix_col(col_in);
        acc_nxt = acc;
        case (col)
            2'd0: acc_nxt[127:96] = col_out;
            2'd1: acc_nxt[95:64]  = col_out;
            2'd2: acc_nxt[63:32]  = col_out;
            2'd3: acc_nxt[31:0]   = col_out;
        endcase
    end

    // datapath registers; the output only updates on the completion edge
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            col          <= 2'd0;
            work         <= '0;
            acc          <= '0;
            ModifiedText <= '0;
            Ry           <= 1'b0;
        end else begin
            if (load) begin
                work <= Text;
                col  <= 2'd0;
            end
            if (step) begin
                acc <= acc_nxt;
                col <= col + 2'd1;
            end
            Ry <= done;
            if (done) begin
                ModifiedText <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
module tb_inv_mix_columns_iter;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         En = 1'b0;
    logic [127:0] Text = '0;
    logic         Ry;
    logic [127:0] ModifiedText;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [127:0] prev_mt = '0;
    logic [127:0] exp_mt;
    logic [127:0] vec [20];

    inv_mix_columns_iter dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .En           (En),
        .Text         (Text),
        .Ry           (Ry),
        .ModifiedText (ModifiedText)
    );

    always #5 Clk = ~Clk;

    // GF(2^8) product: carry-less polynomial multiply, then reduce modulo 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // InvMixColumns as a circulant matrix product over each column
    function automatic logic [127:0] ref_imc(input logic [127:0] t);
        logic [7:0]   s [16];
        logic [7:0]   coef [4];
        logic [7:0]   b;
        logic [127:0] r;
        coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
        for (int k = 0; k < 16; k++) s[k] = t[127 - 8*k -: 8];
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                b = '0;
                for (int j = 0; j < 4; j++)
                    b = b ^ gmul(coef[(j - row + 4) % 4], s[4*c + j]);
                r[127 - 8*(4*c + row) -: 8] = b;
            end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // one-cycle En, Text scrambled after the accepting edge
    task automatic run_block(input logic [127:0] t, input string tag);
        logic [127:0] exp;
        exp  = ref_imc(t);
        Text = t;
        En   = 1'b1;
        tick();
        En   = 1'b0;
        Text = rnd128();
        chk_bit({tag, " ry_after_accept"}, Ry, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_bit({tag, " ry_busy"}, Ry, 1'b0);
            chk({tag, " mt_hold"}, ModifiedText, prev_mt);
        end
        tick();
        chk_bit({tag, " ry_done"}, Ry, 1'b1);
        chk({tag, " mt_done"}, ModifiedText, exp);
        tick();
        chk_bit({tag, " ry_drop"}, Ry, 1'b0);
        chk({tag, " mt_keep"}, ModifiedText, exp);
        prev_mt = exp;
    endtask

    initial begin
        // reset with no clock edge involved
        #1 Rst = 1'b1;
        #1;
        chk_bit("reset ry", Ry, 1'b0);
        chk("reset mt", ModifiedText, '0);
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_bit("idle ry", Ry, 1'b0);
        end
        chk("idle mt", ModifiedText, '0);

        // known vectors
        chk("ref fips", ref_imc(128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6),
            128'hDB135345_F20A225C_01010101_C6C6C6C6);
        run_block(128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6, "fips");
        chk("fips literal", ModifiedText, 128'hDB135345_F20A225C_01010101_C6C6C6C6);
        run_block(128'hD5D5D7D6_4D7EBDF8_00000000_FFFFFFFF, "vec2");
        chk("vec2 literal", ModifiedText, 128'hD4D4D4D5_2D26314C_00000000_FFFFFFFF);

        // random blocks
        for (int i = 0; i < 4; i++) run_block(rnd128(), "rand");

        // En pulsed and Text changed while busy
        vec[0] = rnd128();
        Text = vec[0];
        En   = 1'b1;
        tick();
        En   = 1'b0;
        Text = rnd128();
        tick();
        chk_bit("mid ry1", Ry, 1'b0);
        En   = 1'b1;
        Text = rnd128();
        tick();
        chk_bit("mid ry2", Ry, 1'b0);
        chk("mid mt2", ModifiedText, prev_mt);
        Text = rnd128();
        tick();
        chk_bit("mid ry3", Ry, 1'b0);
        chk("mid mt3", ModifiedText, prev_mt);
        En = 1'b0;
        tick();
        chk_bit("mid ry_done", Ry, 1'b1);
        chk("mid mt_done", ModifiedText, ref_imc(vec[0]));
        prev_mt = ref_imc(vec[0]);
        tick();
        chk_bit("mid ry_drop", Ry, 1'b0);
        chk("mid mt_keep", ModifiedText, prev_mt);

        // En held high: accepts every 5th edge, result 4 edges later
        exp_mt = prev_mt;
        En = 1'b1;
        for (int i = 0; i < 20; i++) begin
            vec[i] = (i % 2 == 0) ? rnd128() : 128'hD5D5D7D6_4D7EBDF8_00000000_FFFFFFFF;
            Text = vec[i];
            tick();
            if (i % 5 == 4) exp_mt = ref_imc(vec[i - 4]);
            chk_bit("held ry", Ry, (i % 5 == 4));
            chk("held mt", ModifiedText, exp_mt);
        end
        En = 1'b0;
        tick();
        chk_bit("held ry_end", Ry, 1'b0);
        prev_mt = exp_mt;

        // reset two edges into a block
        Text = rnd128();
        En   = 1'b1;
        tick();
        En   = 1'b0;
        tick();
        tick();
        #3 Rst = 1'b1;
        #1;
        chk_bit("rstmid ry", Ry, 1'b0);
        chk("rstmid mt", ModifiedText, '0);
        tick();
        tick();
        @(negedge Clk);
        Rst = 1'b0;
        prev_mt = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_bit("rstmid no_ry", Ry, 1'b0);
            chk("rstmid mt_zero", ModifiedText, '0);
        end
        run_block(rnd128(), "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
